// File: rtl/invsqrt_pkg.sv
// Shared constants and types for the inverse-square-root pipeline.
package invsqrt_pkg;

  // Quiet NaN substituted for errored results.
  localparam logic [31:0] INVSQRT_NAN        = 32'h7FC00000;
  // Initial-estimate constant, shared with the init stage.
  localparam logic [31:0] INVSQRT_MAGIC      = 32'h5f3759df;
  // Default number of output FIFO entries.
  localparam int          INVSQRT_FIFO_DEPTH = 4;
  // Width of one stored result entry.
  localparam int          INVSQRT_ENTRY_W    = 33;

  // One buffered result: error flag plus the 32-bit word.
  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } result_entry_t;

endpackage : invsqrt_pkg

// File: rtl/invsqrt_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers, full/empty and a drop flag.
// A write into a full FIFO is accepted only when a read happens in the same
// cycle; otherwise it is dropped and o_drop pulses.
module invsqrt_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_drop,
  output logic             o_push_fire,
  output logic             o_pop_fire
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop_fire;
  logic w_push_fire;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_fire  = i_pop && !w_empty;
  // A pop frees the head slot this cycle, so a full FIFO can still take a write.
  assign w_push_fire = i_push && (!w_full || w_pop_fire);

  assign o_valid     = !w_empty;
  assign o_full      = w_full;
  assign o_drop      = i_push && w_full && !w_pop_fire;
  assign o_push_fire = w_push_fire;
  assign o_pop_fire  = w_pop_fire;
  // Head is driven from registered state only; zero when nothing is stored.
  assign o_rdata     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers; they wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_fire)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Write the storage array on an accepted push.
  // NOTE: storage is not reset; pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push_fire) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule : invsqrt_fifo

// File: rtl/invsqrt_pipe_out.sv
// Output collector at the tail of the inverse-square-root pipeline.
// Substitutes a quiet NaN for errored results, buffers them, and hands them
// to the consumer over valid/ready with a sticky overflow flag.
// Optional statistics counters are built when INVSQRT_OUT_STATS_EN is defined;
// otherwise cnt_results/cnt_errors are tied to zero.
module invsqrt_pipe_out
  import invsqrt_pkg::*;
#(
  parameter int          DEPTH    = INVSQRT_FIFO_DEPTH,
  parameter logic [31:0] NAN_WORD = INVSQRT_NAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [30:0] y_in,
  input  logic        error_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        err_out,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic [15:0] cnt_results,
  output logic [15:0] cnt_errors
);

  result_entry_t w_entry;
  result_entry_t w_head;
  logic [INVSQRT_ENTRY_W-1:0] w_rdata;
  logic w_full;
  logic w_drop;
  logic w_push_fire;
  logic w_pop_fire;
  logic r_overflow;

  // Build the stored entry: errored results become the quiet NaN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    w_entry      = '0;
    w_entry.err  = error_in;
    w_entry.word = error_in ? NAN_WORD : {1'b0, y_in};
  end

  invsqrt_fifo #(
    .WIDTH (INVSQRT_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (valid_in),
    .i_wdata     (w_entry),
    .i_pop       (out_ready),
    .o_rdata     (w_rdata),
    .o_valid     (out_valid),
    .o_full      (w_full),
    .o_drop      (w_drop),
    .o_push_fire (w_push_fire),
    .o_pop_fire  (w_pop_fire)
  );

  assign w_head   = result_entry_t'(w_rdata);
  assign data_out = w_head.word;
  assign err_out  = w_head.err;
  assign overflow = r_overflow;

  // Sticky overflow: a drop sets it, ovf_clr clears it, set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_overflow <= 1'b0;
    else if (w_drop)   r_overflow <= 1'b1;
    else if (ovf_clr)  r_overflow <= 1'b0;
  end

`ifdef INVSQRT_OUT_STATS_EN
  logic [15:0] r_cnt_results;
  logic [15:0] r_cnt_errors;

  // Count pops and accepted error pushes; both wrap at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_results <= '0;
      r_cnt_errors  <= '0;
    end else begin
      if (w_pop_fire)              r_cnt_results <= r_cnt_results + 16'd1;
      if (w_push_fire && error_in) r_cnt_errors  <= r_cnt_errors + 16'd1;
    end
  end

  assign cnt_results = r_cnt_results;
  assign cnt_errors  = r_cnt_errors;

  logic w_unused;
  assign w_unused = w_full;
`else
  assign cnt_results = 16'h0;
  assign cnt_errors  = 16'h0;

  logic w_unused;
  assign w_unused = ^{w_full, w_push_fire, w_pop_fire};
`endif

endmodule : invsqrt_pipe_out
